// File: rtl/gpr_wb_ctrl_pkg.sv
// Shared widths, default depths and the result-buffer entry layout for the
// GPR writeback controller.
package gpr_wb_ctrl_pkg;

  localparam int REG_ADDR_W        = 5;
  localparam int WORD_DATA_W       = 32;
  localparam int NUM_REGS          = 1 << REG_ADDR_W;
  localparam int PEND_CNT_W        = 3;
  localparam int LD_FIFO_DEPTH_DEF = 4;
  localparam int WB_BUF_DEPTH_DEF  = 2;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]  addr;
    logic [WORD_DATA_W-1:0] data;
  } wb_entry_t;

  localparam int WB_ENTRY_W = $bits(wb_entry_t);

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/gpr_wb_ctrl_wb_fifo.sv
// Small parameterised FIFO with occupancy count; pushes when full and pops
// when empty are ignored so the caller decides the protocol policy.
module wb_fifo
  import gpr_wb_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push_s;
  logic             pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  always_comb begin
    push_s = push_i & (cnt_q != CNT_W'(DEPTH));
    pop_s  = pop_i & (cnt_q != '0);
    rd_d   = pop_s  ? ptr_inc(rd_q) : rd_q;
    wr_d   = push_s ? ptr_inc(wr_q) : wr_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_s) begin
      mem_q[wr_q] <= din_i;
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/gpr_wb_ctrl.sv
// Register-file writeback arbiter (ALU first, buffered in-order loads second)
// with a per-register pending-load scoreboard that stalls decode on hazards.
module gpr_wb_ctrl
  import gpr_wb_ctrl_pkg::*;
#(
  parameter int LD_FIFO_DEPTH = LD_FIFO_DEPTH_DEF,
  parameter int WB_BUF_DEPTH  = WB_BUF_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset_,
  input  logic                   AluWE_,
  input  logic [REG_ADDR_W-1:0]  AluAddr,
  input  logic [WORD_DATA_W-1:0] AluData,
  input  logic                   LdIssue_,
  input  logic [REG_ADDR_W-1:0]  LdIssueAddr,
  input  logic                   LdDone_,
  input  logic [WORD_DATA_W-1:0] LdData,
  output logic                   LdFull,
  output logic                   LdBufFull,
  input  logic [REG_ADDR_W-1:0]  DecRdAddr0,
  input  logic [REG_ADDR_W-1:0]  DecRdAddr1,
  input  logic                   DecDstValid_,
  input  logic [REG_ADDR_W-1:0]  DecDstAddr,
  output logic                   Stall,
  output logic                   ErrOvf,
  output logic                   WE_,
  output logic [REG_ADDR_W-1:0]  WrAddr,
  output logic [WORD_DATA_W-1:0] WrData
);

  localparam int AF_CNT_W = cnt_width(LD_FIFO_DEPTH);
  localparam int WB_CNT_W = cnt_width(WB_BUF_DEPTH);

  logic [REG_ADDR_W-1:0] af_head_s;
  logic [AF_CNT_W-1:0]   af_cnt_s;
  wb_entry_t             wb_head_s;
  wb_entry_t             wb_din_s;
  logic [WB_CNT_W-1:0]   wb_cnt_s;

  logic                  ld_full_s;
  logic                  buf_full_s;
  logic                  issue_ok_s;
  logic                  done_ok_s;
  logic                  drain_s;
  logic                  viol_s;
  logic [NUM_REGS-1:0]   haz_s;

  logic [PEND_CNT_W-1:0] pend_q [NUM_REGS];
  logic [PEND_CNT_W-1:0] pend_d [NUM_REGS];
  logic                  err_q, err_d;

  wb_fifo #(
    .WIDTH (REG_ADDR_W),
    .DEPTH (LD_FIFO_DEPTH),
    .CNT_W (AF_CNT_W)
  ) u_addr_fifo (
    .clk     (clk),
    .rst_n   (reset_),
    .push_i  (issue_ok_s),
    .pop_i   (done_ok_s),
    .din_i   (LdIssueAddr),
    .dout_o  (af_head_s),
    .count_o (af_cnt_s)
  );

  wb_fifo #(
    .WIDTH (WB_ENTRY_W),
    .DEPTH (WB_BUF_DEPTH),
    .CNT_W (WB_CNT_W)
  ) u_wb_buf (
    .clk     (clk),
    .rst_n   (reset_),
    .push_i  (done_ok_s),
    .pop_i   (drain_s),
    .din_i   (wb_din_s),
    .dout_o  (wb_head_s),
    .count_o (wb_cnt_s)
  );

  // Protocol decode: accepted events, violations and buffer drain.
  always_comb begin
    ld_full_s      = (af_cnt_s == AF_CNT_W'(LD_FIFO_DEPTH));
    buf_full_s     = (wb_cnt_s == WB_CNT_W'(WB_BUF_DEPTH));
    issue_ok_s     = !LdIssue_ && !ld_full_s;
    done_ok_s      = !LdDone_ && !buf_full_s && (af_cnt_s != '0);
    drain_s        = AluWE_ && (wb_cnt_s != '0);
    viol_s         = (!LdIssue_ && ld_full_s) ||
                     (!LdDone_ && (buf_full_s || (af_cnt_s == '0)));
    wb_din_s.addr  = af_head_s;
    wb_din_s.data  = LdData;
    err_d          = err_q | viol_s;
  end

  // Write-port mux; load data only ever reaches the port through the buffer.
  always_comb begin
    WE_    = 1'b1;
    WrAddr = '0;
    WrData = '0;
    if (!AluWE_) begin
      WE_    = 1'b0;
      WrAddr = AluAddr;
      WrData = AluData;
    end else if (drain_s) begin
      WE_    = 1'b0;
      WrAddr = wb_head_s.addr;
      WrData = wb_head_s.data;
    end else begin
      WE_    = 1'b1;
    end
  end

  // Scoreboard next state and hazard; a drain of the last pending write releases.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      logic inc_v;
      logic dec_v;
      inc_v = issue_ok_s && (LdIssueAddr == REG_ADDR_W'(i));
      dec_v = drain_s && (wb_head_s.addr == REG_ADDR_W'(i));
      case ({inc_v, dec_v})
        2'b10:   pend_d[i] = pend_q[i] + PEND_CNT_W'(1);
        2'b01:   pend_d[i] = pend_q[i] - PEND_CNT_W'(1);
        default: pend_d[i] = pend_q[i];
      endcase
      haz_s[i] = (pend_q[i] != '0) &&
                 !(dec_v && (pend_q[i] == PEND_CNT_W'(1)));
    end
  end

  // Scoreboard and sticky error state.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        pend_q[i] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        pend_q[i] <= pend_d[i];
      end
      err_q <= err_d;
    end
  end

  assign Stall     = haz_s[DecRdAddr0] | haz_s[DecRdAddr1] |
                     (!DecDstValid_ & haz_s[DecDstAddr]);
  assign LdFull    = ld_full_s;
  assign LdBufFull = buf_full_s;
  assign ErrOvf    = err_q;

endmodule

// File: tb/tb_gpr_wb_ctrl.sv
// Directed table-driven bench for gpr_wb_ctrl plus hand sequences for reset
// mid-operation and done-with-empty-FIFO.
module tb_gpr_wb_ctrl;

  logic        clk = 1'b0;
  logic        reset_;
  logic        AluWE_;
  logic [4:0]  AluAddr;
  logic [31:0] AluData;
  logic        LdIssue_;
  logic [4:0]  LdIssueAddr;
  logic        LdDone_;
  logic [31:0] LdData;
  logic        LdFull;
  logic        LdBufFull;
  logic [4:0]  DecRdAddr0;
  logic [4:0]  DecRdAddr1;
  logic        DecDstValid_;
  logic [4:0]  DecDstAddr;
  logic        Stall;
  logic        ErrOvf;
  logic        WE_;
  logic [4:0]  WrAddr;
  logic [31:0] WrData;

  int n_checks = 0;
  int n_fail   = 0;

  gpr_wb_ctrl dut (
    .clk          (clk),
    .reset_       (reset_),
    .AluWE_       (AluWE_),
    .AluAddr      (AluAddr),
    .AluData      (AluData),
    .LdIssue_     (LdIssue_),
    .LdIssueAddr  (LdIssueAddr),
    .LdDone_      (LdDone_),
    .LdData       (LdData),
    .LdFull       (LdFull),
    .LdBufFull    (LdBufFull),
    .DecRdAddr0   (DecRdAddr0),
    .DecRdAddr1   (DecRdAddr1),
    .DecDstValid_ (DecDstValid_),
    .DecDstAddr   (DecDstAddr),
    .Stall        (Stall),
    .ErrOvf       (ErrOvf),
    .WE_          (WE_),
    .WrAddr       (WrAddr),
    .WrData       (WrData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        alu_n;
    logic [4:0]  alu_a;
    logic [31:0] alu_d;
    logic        iss_n;
    logic [4:0]  iss_a;
    logic        done_n;
    logic [31:0] ld_d;
    logic [4:0]  rd0;
    logic [4:0]  rd1;
    logic        dv_n;
    logic [4:0]  dst;
    logic [41:0] exp;
  } vec_t;

  vec_t vecs[28];

  function automatic logic [41:0] pack_exp(input logic we_n, input logic [4:0] wa, input logic [31:0] wd,
                                           input logic st, input logic lf, input logic bf, input logic er);
    return {we_n, wa, wd, st, lf, bf, er};
  endfunction

  function automatic vec_t mkv(input logic alu_n, input logic [4:0] alu_a, input logic [31:0] alu_d,
                               input logic iss_n, input logic [4:0] iss_a, input logic done_n,
                               input logic [31:0] ld_d, input logic [4:0] rd0, input logic [4:0] rd1,
                               input logic dv_n, input logic [4:0] dst, input logic [41:0] exp);
    vec_t v;
    v.alu_n = alu_n; v.alu_a = alu_a; v.alu_d = alu_d;
    v.iss_n = iss_n; v.iss_a = iss_a; v.done_n = done_n; v.ld_d = ld_d;
    v.rd0 = rd0; v.rd1 = rd1; v.dv_n = dv_n; v.dst = dst; v.exp = exp;
    return v;
  endfunction

  function automatic logic [41:0] outs();
    return {WE_, WrAddr, WrData, Stall, LdFull, LdBufFull, ErrOvf};
  endfunction

  task automatic check(input string name, input logic [41:0] got, input logic [41:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got {we_n,wa,wd,stall,full,bfull,err}=%h expected %h", name, got, exp);
    end
  endtask

  task automatic drive_idle();
    AluWE_ = 1'b1; AluAddr = 5'd0; AluData = 32'h0;
    LdIssue_ = 1'b1; LdIssueAddr = 5'd0; LdDone_ = 1'b1; LdData = 32'h0;
    DecRdAddr0 = 5'd0; DecRdAddr1 = 5'd0; DecDstValid_ = 1'b1; DecDstAddr = 5'd0;
  endtask

  initial begin
    // alu_n alu_a alu_d | iss_n iss_a | done_n ld_d | rd0 rd1 dv_n dst | we_n wa wd stall full bfull err
    vecs[0]  = mkv(1'b0, 5'd5, 32'h1234, 1'b1, 5'd0, 1'b1, 32'h0,    5'd5, 5'd0, 1'b1, 5'd0, pack_exp(1'b0, 5'd5, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs[1]  = mkv(1'b1, 5'd0, 32'h0,    1'b0, 5'd3, 1'b1, 32'h0,    5'd3, 5'd0, 1'b1, 5'd0, pack_exp(1'b1, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0));
    vecs[2]  = mkv(1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 1'b1, 32'h0,    5'd3, 5'd0, 1'b1, 5'd0, pack_exp(1'b1, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    vecs[3]  = mkv(1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 1'b0, 32'hCAFE, 5'd3, 5'd0, 1'b1, 5'd0, pack_exp(1'b1, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    vecs[4]  = mkv(1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 1'b1, 32'h0,    5'd3, 5'd0, 1'b1, 5'd0, pack_exp(1'b0, 5'd3, 32'hCAFE, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs[5]  = mkv(1'b1, 5'd0, 32'h0,    1'b0, 5'd2, 1'b1, 32'h0,    5'd3, 5'd0, 1'b1, 5'd0, pack_exp(1'b1, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0));
    vecs[6]  = mkv(1'b0, 5'd1, 32'h11,   1'b1, 5'd0, 1'b0, 32'hBEEF, 5'd2, 5'd0, 1'b1, 5'd0, pack_exp(1'b0, 5'd1, 32'h11,   1'b1, 1'b0, 1'b0, 1'b0));
    vecs[7]  = mkv(1'b0, 5'd1, 32'h12,   1'b1, 5'd0, 1'b1, 32'h0,    5'd2, 5'd0, 1'b1, 5'd0, pack_exp(1'b0, 5'd1, 32'h12,   1'b1, 1'b0, 1'b0, 1'b0));
    vecs[8]  = mkv(1'b0, 5'd1, 32'h13,   1'b1, 5'd0, 1'b1, 32'h0,    5'd2, 5'd0, 1'b1, 5'd0, pack_exp(1'b0, 5'd1, 32'h13,   1'b1, 1'b0, 1'b0, 1'b0));
    vecs[9]  = mkv(1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 1'b1, 32'h0,    5'd2, 5'd0, 1'b1, 5'd0, pack_exp(1'b0, 5'd2, 32'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs[10] = mkv(1'b1, 5'd0, 32'h0,    1'b0, 5'd7, 1'b1, 32'h0,    5'd7, 5'd0, 1'b1, 5'd0, pack_exp(1'b1, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0));
    vecs[11] = mkv(1'b1, 5'd0, 32'h0,    1'b0, 5'd7, 1'b1, 32'h0,    5'd0, 5'd0, 1'b0, 5'd7, pack_exp(1'b1, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0));
    vecs[12] = mkv(1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 1'b0, 32'h70,   5'd0, 5'd0, 1'b1, 5'd7, pack_exp(1'b1, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0));
    vecs[13] = mkv(1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 1'b0, 32'h71,   5'd0, 5'd7, 1'b1, 5'd0, pack_exp(1'b0, 5'd7, 32'h70,   1'b1, 1'b0, 1'b0, 1'b0));
    vecs[14] = mkv(1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 1'b1, 32'h0,    5'd7, 5'd0, 1'b1, 5'd0, pack_exp(1'b0, 5'd7, 32'h71,   1'b0, 1'b0, 1'b0, 1'b0));
    vecs[15] = mkv(1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 1'b1, 32'h0,    5'd7, 5'd0, 1'b1, 5'd0, pack_exp(1'b1, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0));
    for (int i = 16; i < 20; i++) begin
      vecs[i] = mkv(1'b1, 5'd0, 32'h0,   1'b0, 5'd4, 1'b1, 32'h0,    5'd0, 5'd0, 1'b1, 5'd0, pack_exp(1'b1, 5'd0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0));
    end
    vecs[20] = mkv(1'b1, 5'd0, 32'h0,    1'b0, 5'd4, 1'b1, 32'h0,    5'd0, 5'd0, 1'b1, 5'd0, pack_exp(1'b1, 5'd0, 32'h0,    1'b0, 1'b1, 1'b0, 1'b0));
    vecs[21] = mkv(1'b0, 5'd9, 32'h90,   1'b1, 5'd0, 1'b0, 32'hA0,   5'd0, 5'd0, 1'b1, 5'd0, pack_exp(1'b0, 5'd9, 32'h90,   1'b0, 1'b1, 1'b0, 1'b1));
    vecs[22] = mkv(1'b0, 5'd9, 32'h91,   1'b1, 5'd0, 1'b0, 32'hA1,   5'd0, 5'd0, 1'b1, 5'd0, pack_exp(1'b0, 5'd9, 32'h91,   1'b0, 1'b0, 1'b0, 1'b1));
    vecs[23] = mkv(1'b0, 5'd9, 32'h92,   1'b1, 5'd0, 1'b0, 32'hA2,   5'd0, 5'd0, 1'b1, 5'd0, pack_exp(1'b0, 5'd9, 32'h92,   1'b0, 1'b0, 1'b1, 1'b1));
    vecs[24] = mkv(1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 1'b1, 32'h0,    5'd4, 5'd0, 1'b1, 5'd0, pack_exp(1'b0, 5'd4, 32'hA0,   1'b1, 1'b0, 1'b1, 1'b1));
    vecs[25] = mkv(1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 1'b1, 32'h0,    5'd4, 5'd0, 1'b1, 5'd0, pack_exp(1'b0, 5'd4, 32'hA1,   1'b1, 1'b0, 1'b0, 1'b1));
    vecs[26] = mkv(1'b1, 5'd0, 32'h0,    1'b1, 5'd0, 1'b1, 32'h0,    5'd4, 5'd0, 1'b1, 5'd0, pack_exp(1'b1, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1));
    vecs[27] = mkv(1'b0, 5'd9, 32'h93,   1'b0, 5'd6, 1'b0, 32'hB0,   5'd4, 5'd0, 1'b1, 5'd0, pack_exp(1'b0, 5'd9, 32'h93,   1'b1, 1'b0, 1'b0, 1'b1));

    drive_idle();
    reset_ = 1'b0;
    #12;
    check("reset_state", outs(), pack_exp(1'b1, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1 reset_ = 1'b1;

    for (int i = 0; i < 28; i++) begin
      @(posedge clk);
      #1;
      AluWE_ = vecs[i].alu_n; AluAddr = vecs[i].alu_a; AluData = vecs[i].alu_d;
      LdIssue_ = vecs[i].iss_n; LdIssueAddr = vecs[i].iss_a;
      LdDone_ = vecs[i].done_n; LdData = vecs[i].ld_d;
      DecRdAddr0 = vecs[i].rd0; DecRdAddr1 = vecs[i].rd1;
      DecDstValid_ = vecs[i].dv_n; DecDstAddr = vecs[i].dst;
      #3;
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Reset with two loads pending and one result buffered.
    @(posedge clk);
    #1;
    drive_idle();
    DecRdAddr0 = 5'd4;
    DecRdAddr1 = 5'd6;
    reset_ = 1'b0;
    #1;
    check("mid_reset", outs(), pack_exp(1'b1, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1 reset_ = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      check($sformatf("post_reset%0d", i), outs(), pack_exp(1'b1, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clk);
      #1;
    end

    // Load return with nothing outstanding: dropped, flagged, never written.
    DecRdAddr0 = 5'd0;
    DecRdAddr1 = 5'd0;
    LdDone_ = 1'b0;
    LdData = 32'hDEAD;
    #3;
    check("done_empty_cyc", outs(), pack_exp(1'b1, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1 LdDone_ = 1'b1;
    #3;
    check("done_empty_err", outs(), pack_exp(1'b1, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    @(posedge clk);
    #4;
    check("done_empty_nowr", outs(), pack_exp(1'b1, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
